// File: rtl/instruction_fetch.sv
// Fetch stage: walks a fetch pointer through synchronous instruction memory and
// buffers fetched words in a small prefetch FIFO ahead of the control matrix.
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 24,
    parameter int DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imemRead,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               redirectValid,
    input  logic [ADDR_W-1:0]  redirectAddr,
    output logic               commandValid,
    input  logic               commandReady,
    output logic [INSTR_W-1:0] commandOut,
    output logic [ADDR_W-1:0]  commandAddr,
    output logic [ADDR_W-1:0]  fetchPointer
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] SLOTS = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               inflight;
    logic [ADDR_W-1:0]  addr_d;
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               push;
    logic               pop;

    // A read in flight already owns a slot, so issue never overruns the FIFO.
    always_comb begin
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue     = reset_n && !redirectValid && (occupancy < SLOTS);
        push      = inflight && !redirectValid;
        pop       = commandValid && commandReady;
    end

    assign imemRead     = issue;
    assign imemAddr     = fetchPointer;
    assign commandValid = (count != '0);
    assign commandOut   = commandValid ? data_q[rd_ptr] : '0;
    assign commandAddr  = commandValid ? addr_q[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetchPointer <= '0;
            inflight     <= 1'b0;
            addr_d       <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else if (redirectValid) begin
            fetchPointer <= redirectAddr;
            inflight     <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetchPointer <= fetchPointer + ADDR_W'(1);
                addr_d       <= fetchPointer;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr] <= imemData;
            addr_q[wr_ptr] <= addr_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random ready/redirect
// traffic, checked against an issue-time queue model of the fetch stream.
module tb_instruction_fetch;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic        imemRead;
    logic [7:0]  imemAddr;
    logic [23:0] imemData;
    logic        redirectValid;
    logic [7:0]  redirectAddr;
    logic        commandValid;
    logic        commandReady;
    logic [23:0] commandOut;
    logic [7:0]  commandAddr;
    logic [7:0]  fetchPointer;

    int errors;
    int checks;
    int reads;
    int cyc;
    int q[$];
    logic [7:0] fp;
    logic [7:0] exp_addr;

    instruction_fetch #(
        .ADDR_W (8),
        .INSTR_W(24),
        .DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imemRead     (imemRead),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .redirectValid(redirectValid),
        .redirectAddr (redirectAddr),
        .commandValid (commandValid),
        .commandReady (commandReady),
        .commandOut   (commandOut),
        .commandAddr  (commandAddr),
        .fetchPointer (fetchPointer)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // mem[a] = a * 0x010101
    function automatic logic [23:0] word(input logic [7:0] a);
        return {a, a, a};
    endfunction

    always @(posedge clock) begin
        if (imemRead) imemData <= word(imemAddr);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive, check, advance model across next posedge.
    task automatic step(input logic rdy, input logic rv, input logic [7:0] ra);
        logic exp_valid;
        logic exp_read;
        commandReady  = rdy;
        redirectValid = rv;
        redirectAddr  = ra;
        #1;
        exp_valid = (q.size() > 0) && (cyc - q[0] >= 2);
        exp_read  = (q.size() < DEPTH) && !rv;
        check("valid", commandValid, exp_valid);
        check("read", imemRead, exp_read);
        check("fptr", fetchPointer, fp);
        if (exp_read) check("iaddr", imemAddr, fp);
        if (exp_valid) begin
            check("caddr", commandAddr, exp_addr);
            check("cout", commandOut, word(exp_addr));
        end
        if (imemRead) reads++;
        if (exp_valid && rdy) begin
            void'(q.pop_front());
            exp_addr++;
        end
        if (rv) begin
            q.delete();
            fp       = ra;
            exp_addr = ra;
        end else if (exp_read) begin
            q.push_back(cyc);
            fp++;
        end
        cyc++;
        @(negedge clock);
    endtask

    // Asserts reset asynchronously, checks outputs before any edge,
    // releases at a negedge.
    task automatic do_reset();
        reset_n       = 1'b0;
        redirectValid = 1'b0;
        #1;
        check("rst_valid", commandValid, 1'b0);
        check("rst_read", imemRead, 1'b0);
        check("rst_fptr", fetchPointer, 8'h00);
        check("rst_iaddr", imemAddr, 8'h00);
        check("rst_cout", commandOut, 24'h0);
        check("rst_caddr", commandAddr, 8'h00);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        fp       = 8'h00;
        exp_addr = 8'h00;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reads         = 0;
        cyc           = 0;
        fp            = 8'h00;
        exp_addr      = 8'h00;
        reset_n       = 1'b0;
        redirectValid = 1'b0;
        redirectAddr  = 8'h00;
        commandReady  = 1'b0;
        @(negedge clock);
        do_reset();

        // streaming from reset with ready held high
        repeat (20) step(1'b1, 1'b0, 8'h00);

        // backpressure from a fresh start
        do_reset();
        reads = 0;
        repeat (10) step(1'b0, 1'b0, 8'h00);
        check("t2_reads", reads, DEPTH);
        check("t2_hold", commandOut, word(8'h00));
        repeat (10) step(1'b1, 1'b0, 8'h00);

        // redirect with FIFO nearly full and a read in flight
        repeat (2) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h40);
        repeat (2) step(1'b1, 1'b0, 8'h00);
        check("t3_valid", commandValid, 1'b1);
        check("t3_addr", commandAddr, 8'h40);
        check("t3_out", commandOut, word(8'h40));
        repeat (6) step(1'b1, 1'b0, 8'h00);

        // wrap through the top of the address space
        step(1'b1, 1'b1, 8'hFE);
        repeat (10) step(1'b1, 1'b0, 8'h00);

        // redirect coinciding with a pop, then a second redirect
        step(1'b1, 1'b1, 8'h10);
        step(1'b1, 1'b1, 8'h20);
        repeat (2) step(1'b1, 1'b0, 8'h00);
        check("t5_addr", commandAddr, 8'h20);
        repeat (6) step(1'b1, 1'b0, 8'h00);

        // asynchronous reset mid-stream
        @(posedge clock);
        #2;
        check("t6_valid_before", commandValid, 1'b1);
        do_reset();
        repeat (10) step(1'b1, 1'b0, 8'h00);

        // random traffic
        repeat (3000) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
